// File: rtl/pool_layer_ctrl.sv
// pool_layer_ctrl: drives a 2x2/stride-2 max pooler over a multi-channel feature map,
// streaming each channel from the source buffer and routing pooled results to the dest buffer.
module pool_layer_ctrl #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int MAX_CH     = 16,
  parameter int DATA_W     = 22,
  parameter int ADDR_W     = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic [4:0]        cmd_num_ch,
  output logic              busy,
  output logic              layer_done,
  output logic              err_count,
  input  logic              rd_gnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pool_start,
  output logic              pool_pixel_valid,
  output logic [DATA_W-1:0] pool_pixel_in,
  input  logic [DATA_W-1:0] pool_result_in,
  input  logic              pool_result_vld,
  input  logic              pool_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  // state  | meaning
  // IDLE   | waiting for cmd_start
  // START  | one-cycle pooler start pulse, channel counters cleared
  // STREAM | reading W*H pixels of the current channel, gated by rd_gnt
  // DRAIN  | all pixels issued, waiting for pool_done
  // DONE   | layer finished; layer_done follows next cycle
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam int PIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int RES   = PIX / 4;
  localparam int PIX_W = $clog2(PIX);
  localparam int RES_W = $clog2(RES) + 1;

  logic [2:0]       state;
  logic [4:0]       num_ch;
  logic [4:0]       ch;
  logic [4:0]       ch_next;
  logic [4:0]       num_clamped;
  logic [PIX_W-1:0] pix_cnt;
  logic [RES_W-1:0] res_cnt;
  logic [RES_W-1:0] res_total;

  assign ch_next     = ch + 5'd1;
  assign num_clamped = (cmd_num_ch > 5'(MAX_CH)) ? 5'(MAX_CH) : cmd_num_ch;
  // a result arriving in the same cycle as pool_done still belongs to this channel
  assign res_total   = res_cnt + RES_W'(pool_result_vld);

  assign busy       = (state != ST_IDLE);
  assign pool_start = (state == ST_START);
  assign rd_en      = (state == ST_STREAM) && rd_gnt;
  assign rd_addr    = ADDR_W'(ch) * ADDR_W'(PIX) + ADDR_W'(pix_cnt);

  assign pool_pixel_in = pool_pixel_valid ? rd_data : '0;

  assign wr_en   = pool_result_vld;
  assign wr_data = pool_result_in;
  assign wr_addr = ADDR_W'(ch) * ADDR_W'(RES) + ADDR_W'(res_cnt[RES_W-2:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      num_ch           <= '0;
      ch               <= '0;
      pix_cnt          <= '0;
      res_cnt          <= '0;
      err_count        <= 1'b0;
      layer_done       <= 1'b0;
      pool_pixel_valid <= 1'b0;
    end else begin
      layer_done       <= 1'b0;
      pool_pixel_valid <= rd_en;
      if (pool_result_vld) res_cnt <= res_cnt + RES_W'(1);
      case (state)
        ST_IDLE: begin
          if (cmd_start) begin
            err_count <= 1'b0;
            num_ch    <= num_clamped;
            ch        <= '0;
            state     <= (num_clamped == 5'd0) ? ST_DONE : ST_START;
          end
        end
        ST_START: begin
          pix_cnt <= '0;
          res_cnt <= '0;
          state   <= ST_STREAM;
        end
        ST_STREAM: begin
          if (rd_gnt) begin
            pix_cnt <= pix_cnt + PIX_W'(1);
            if (pix_cnt == PIX_W'(PIX - 1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pool_done) begin
            if (res_total != RES_W'(RES)) err_count <= 1'b1;
            ch    <= ch_next;
            state <= (ch_next == num_ch) ? ST_DONE : ST_START;
          end
        end
        ST_DONE: begin
          layer_done <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_layer_ctrl.sv
// tb_pool_layer_ctrl: directed bench with a source-buffer model, a behavioural 2x2 max pooler
// and a scoreboard of expected destination writes computed from the source image.
module tb_pool_layer_ctrl;
  localparam int W   = 32;
  localparam int H   = 32;
  localparam int DW  = 22;
  localparam int AW  = 14;
  localparam int PIX = W * H;
  localparam int RES = PIX / 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_start = 1'b0;
  logic [4:0]    cmd_num_ch = '0;
  logic          busy, layer_done, err_count;
  logic          rd_gnt = 1'b1;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          pool_start, pool_pixel_valid;
  logic [DW-1:0] pool_pixel_in;
  logic [DW-1:0] pool_result_in = '0;
  logic          pool_result_vld = 1'b0;
  logic          pool_done = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  always #5 clk = ~clk;

  pool_layer_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAX_CH(16), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_num_ch(cmd_num_ch),
    .busy(busy), .layer_done(layer_done), .err_count(err_count),
    .rd_gnt(rd_gnt), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pool_start(pool_start), .pool_pixel_valid(pool_pixel_valid), .pool_pixel_in(pool_pixel_in),
    .pool_result_in(pool_result_in), .pool_result_vld(pool_result_vld), .pool_done(pool_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  logic signed [DW-1:0] mem  [0:16383];
  logic signed [DW-1:0] pbuf [0:PIX-1];

  function automatic logic signed [DW-1:0] max4(input logic signed [DW-1:0] a, b, c, d);
    logic signed [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // source buffer: data one cycle after the read strobe
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // pooler model; drop_en suppresses exactly one result while held high
  int   pidx = 0;
  logic done_d = 1'b0;
  logic drop_en = 1'b0;
  logic dropped = 1'b0;
  always @(posedge clk) begin
    pool_result_vld <= 1'b0;
    pool_done       <= done_d;
    done_d          <= 1'b0;
    if (rst) begin
      pidx      <= 0;
      pool_done <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      if (pool_start) pidx <= 0;
      else if (pool_pixel_valid) begin
        pbuf[pidx] <= pool_pixel_in;
        if (pidx[5] && pidx[0]) begin
          if (drop_en && !dropped) dropped <= 1'b1;
          else begin
            pool_result_vld <= 1'b1;
            pool_result_in  <= max4(pbuf[pidx-W-1], pbuf[pidx-W], pbuf[pidx-1], pool_pixel_in);
          end
        end
        if (pidx == PIX - 1) done_d <= 1'b1;
        pidx <= pidx + 1;
      end
      if (!drop_en) dropped <= 1'b0;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int exp_rd = 0;
  int n_ps = 0, n_rd = 0, n_wr = 0, n_ld = 0;
  logic chk_wr = 1'b1;
  logic chk_adj = 1'b1;
  logic prev_ps = 1'b0;
  logic [AW+DW-1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic [AW+DW-1:0] e;
    @(posedge clk);
    @(negedge clk);
    if (rd_en) begin
      n_rd++;
      check("rd_en_gnt", 32'(rd_gnt), 32'd1);
      check("rd_addr", 32'(rd_addr), 32'(exp_rd));
      exp_rd++;
      if (chk_adj && rd_addr[9:0] == 10'd0) check("start_before_rd", 32'(prev_ps), 32'd1);
    end
    if (pool_start) n_ps++;
    if (layer_done) n_ld++;
    if (wr_en) begin
      n_wr++;
      if (chk_wr) begin
        if (sb.size() == 0) check("sb_empty", 32'(wr_addr), 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e[AW+DW-1:DW]));
          check("wr_data", 32'(wr_data), 32'(e[DW-1:0]));
        end
      end
    end
    prev_ps = pool_start;
  endtask

  task automatic push_layer(input int n);
    int a;
    for (int ch = 0; ch < n; ch++)
      for (int r = 0; r < H/2; r++)
        for (int c = 0; c < W/2; c++) begin
          a = ch*PIX + 2*r*W + 2*c;
          sb.push_back({AW'(ch*RES + r*(W/2) + c),
                        max4(mem[a], mem[a+1], mem[a+W], mem[a+W+1])});
        end
  endtask

  // mode bits: 0 random grant, 1 mid-layer cmd_start, 2 drop a result on ch 1, 3 abort in ch 2
  task automatic run_layer(input int n, input int mode);
    int cyc;
    cyc = 0;
    exp_rd = 0; n_ps = 0; n_rd = 0; n_wr = 0; n_ld = 0;
    cmd_num_ch = 5'(n);
    cmd_start  = 1'b1;
    rd_gnt     = 1'b1;
    tick();
    cmd_start = 1'b0;
    while (n_ld == 0 && cyc < 6000*n + 20) begin
      if (mode[1] && cyc == 500) begin
        cmd_start  = 1'b1;
        cmd_num_ch = 5'd1;
      end else cmd_start = 1'b0;
      if (mode[2]) drop_en = (exp_rd >= PIX) && (exp_rd < 2*PIX);
      if (mode[3] && exp_rd >= 2*PIX + 100) break;
      rd_gnt = mode[0] ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cyc++;
    end
    drop_en   = 1'b0;
    cmd_start = 1'b0;
    rd_gnt    = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = DW'(i);
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_layer_done", 32'(layer_done), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_pool_start", 32'(pool_start), 32'd0);
    check("rst_pix_valid", 32'(pool_pixel_valid), 32'd0);
    rst = 1'b0;
    tick();

    // single channel, ramp image, full grant
    chk_wr = 1'b1; chk_adj = 1'b1;
    push_layer(1);
    run_layer(1, 0);
    check("t1_layer_done", 32'(n_ld), 32'd1);
    check("t1_starts", 32'(n_ps), 32'd1);
    check("t1_reads", 32'(n_rd), 32'(PIX));
    check("t1_writes", 32'(n_wr), 32'(RES));
    check("t1_sb_left", 32'(sb.size()), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_err", 32'(err_count), 32'd0);
    tick(); tick();
    check("t1_ld_once", 32'(n_ld), 32'd1);

    // three channels, random signed image
    for (int i = 0; i < 16384; i++) mem[i] = DW'($urandom);
    push_layer(3);
    run_layer(3, 0);
    check("t2_layer_done", 32'(n_ld), 32'd1);
    check("t2_starts", 32'(n_ps), 32'd3);
    check("t2_reads", 32'(n_rd), 32'(3*PIX));
    check("t2_writes", 32'(n_wr), 32'(3*RES));
    check("t2_sb_left", 32'(sb.size()), 32'd0);
    check("t2_err", 32'(err_count), 32'd0);

    // random grant bubbles
    for (int i = 0; i < 16384; i++) mem[i] = DW'(i);
    chk_adj = 1'b0;
    push_layer(1);
    run_layer(1, 1);
    check("t3_layer_done", 32'(n_ld), 32'd1);
    check("t3_reads", 32'(n_rd), 32'(PIX));
    check("t3_writes", 32'(n_wr), 32'(RES));
    check("t3_sb_left", 32'(sb.size()), 32'd0);

    // zero channels
    n_ps = 0; n_rd = 0; n_wr = 0; n_ld = 0;
    cmd_num_ch = 5'd0; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_ld_early", 32'(layer_done), 32'd0);
    tick();
    check("t4_ld", 32'(layer_done), 32'd1);
    check("t4_busy_low", 32'(busy), 32'd0);
    tick();
    check("t4_ld_pulse", 32'(layer_done), 32'd0);
    check("t4_no_activity", 32'(n_rd + n_ps + n_wr), 32'd0);

    // dropped result on ch 1 plus an ignored mid-layer cmd_start
    chk_wr = 1'b0; chk_adj = 1'b1;
    run_layer(3, 6);
    check("t5_layer_done", 32'(n_ld), 32'd1);
    check("t5_starts", 32'(n_ps), 32'd3);
    check("t5_reads", 32'(n_rd), 32'(3*PIX));
    check("t5_writes", 32'(n_wr), 32'(3*RES - 1));
    check("t5_err", 32'(err_count), 32'd1);
    repeat (5) tick();
    check("t5_err_sticky", 32'(err_count), 32'd1);

    // reset mid-stream on ch 2, then restart
    chk_wr = 1'b1;
    push_layer(3);
    run_layer(3, 8);
    check("t6_err_cleared", 32'(err_count), 32'd0);
    check("t6_reached_ch2", 32'(exp_rd >= 2*PIX + 100), 32'd1);
    rst = 1'b1;
    tick();
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_rd_en", 32'(rd_en), 32'd0);
    check("t6_rd_addr", 32'(rd_addr), 32'd0);
    check("t6_pool_start", 32'(pool_start), 32'd0);
    check("t6_pix_valid", 32'(pool_pixel_valid), 32'd0);
    check("t6_pix_in", 32'(pool_pixel_in), 32'd0);
    check("t6_layer_done", 32'(layer_done), 32'd0);
    rst = 1'b0;
    sb.delete();
    tick();
    push_layer(1);
    run_layer(1, 0);
    check("t6r_layer_done", 32'(n_ld), 32'd1);
    check("t6r_reads", 32'(n_rd), 32'(PIX));
    check("t6r_writes", 32'(n_wr), 32'(RES));
    check("t6r_sb_left", 32'(sb.size()), 32'd0);
    check("t6r_err", 32'(err_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
